exec_stage: RTL and testbench

Operand-issue and execute pipeline stage for the CPU32 core, sitting directly upstream of the ALU. It accepts decoded instructions over a valid/ready handshake and reads operands from an internal 16×32 register file, forwarding results as needed. It registers opcode and operands into an E-stage register that drives the ALU, then captures the ALU result and writes it back to the register file.

---
 rtl/exec_stage.sv | 97 +++++++++
 tb/tb_exec_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Operand-issue/execute stage: regfile read with optional E-stage forwarding, E register to ALU, writeback one edge later.
// Latency: issue at edge N, writeback at edge N+1. Backpressure: in_ready drops only for a register hazard when FWD_EN=0.
module exec_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_ra,
  input  logic [3:0]  in_rb,
  input  logic        in_use_imm,
  input  logic [15:0] in_imm,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_left,
  output logic [31:0] alu_right,
  input  logic [31:0] alu_out,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic [3:0]  dbg_ra,
  output logic [31:0] dbg_rdata
);

  logic [31:0] regfile [16];
  logic        e_valid;
  logic [3:0]  e_rd;
  logic        fire;
  logic        hazard;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic [31:0] imm_sext;

  // r0 is hardwired to zero, so it never forwards and never causes a hazard.
  always_comb begin
    opnd_a = regfile[in_ra];
    if (in_ra == 4'd0)
      opnd_a = '0;
    else if (FWD_EN && e_valid && (e_rd == in_ra))
      opnd_a = alu_out;

    opnd_b = regfile[in_rb];
    if (in_rb == 4'd0)
      opnd_b = '0;
    else if (FWD_EN && e_valid && (e_rd == in_rb))
      opnd_b = alu_out;

    imm_sext = {{16{in_imm[15]}}, in_imm};

    hazard = !FWD_EN && e_valid && (e_rd != 4'd0) &&
             ((e_rd == in_ra) || (!in_use_imm && (e_rd == in_rb)));
    in_ready = !hazard;
    fire     = in_valid && in_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid   <= 1'b0;
      e_rd      <= '0;
      alu_op    <= '0;
      alu_left  <= '0;
      alu_right <= '0;
    end else begin
      e_valid <= fire;
      if (fire) begin
        e_rd      <= in_rd;
        alu_op    <= in_op;
        alu_left  <= opnd_a;
        alu_right <= in_use_imm ? imm_sext : opnd_b;
      end
    end
  end

  // wb_data is reported even for rd=0; only the regfile write is suppressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      for (int i = 0; i < 16; i++)
        regfile[i] <= '0;
    end else if (e_valid) begin
      if (e_rd != 4'd0)
        regfile[e_rd] <= alu_out;
      wb_valid <= 1'b1;
      wb_rd    <= e_rd;
      wb_data  <= alu_out;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  assign dbg_rdata = (dbg_ra == 4'd0) ? 32'd0 : regfile[dbg_ra];

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: one forwarding instance and one stalling instance, each with a small ALU model.
module tb_exec_stage;

  typedef struct packed {
    logic        vld;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        use_imm;
    logic [15:0] imm;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ins_t        f_in, s_in;
  logic [3:0]  f_dbg, s_dbg;
  logic        f_rdy, s_rdy;
  logic [3:0]  f_alu_op, s_alu_op;
  logic [31:0] f_alu_left, s_alu_left, f_alu_right, s_alu_right;
  logic [31:0] f_alu_out, s_alu_out;
  logic        f_wb_valid, s_wb_valid;
  logic [3:0]  f_wb_rd, s_wb_rd;
  logic [31:0] f_wb_data, s_wb_data, f_dbg_rdata, s_dbg_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Bench ALU: add for 0/2, pass-right for E, {imm16,left16} merge for F.
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r);
    case (op)
      4'h0, 4'h2: alu = l + r;
      4'he:       alu = r;
      4'hf:       alu = {r[15:0], l[15:0]};
      default:    alu = l ^ r;
    endcase
  endfunction

  always_comb f_alu_out = alu(f_alu_op, f_alu_left, f_alu_right);
  always_comb s_alu_out = alu(s_alu_op, s_alu_left, s_alu_right);

  exec_stage #(.FWD_EN(1'b1)) u_fwd (
    .clk(clk), .reset(rst),
    .in_valid(f_in.vld), .in_ready(f_rdy), .in_op(f_in.op), .in_rd(f_in.rd),
    .in_ra(f_in.ra), .in_rb(f_in.rb), .in_use_imm(f_in.use_imm), .in_imm(f_in.imm),
    .alu_op(f_alu_op), .alu_left(f_alu_left), .alu_right(f_alu_right), .alu_out(f_alu_out),
    .wb_valid(f_wb_valid), .wb_rd(f_wb_rd), .wb_data(f_wb_data),
    .dbg_ra(f_dbg), .dbg_rdata(f_dbg_rdata)
  );

  exec_stage #(.FWD_EN(1'b0)) u_stl (
    .clk(clk), .reset(rst),
    .in_valid(s_in.vld), .in_ready(s_rdy), .in_op(s_in.op), .in_rd(s_in.rd),
    .in_ra(s_in.ra), .in_rb(s_in.rb), .in_use_imm(s_in.use_imm), .in_imm(s_in.imm),
    .alu_op(s_alu_op), .alu_left(s_alu_left), .alu_right(s_alu_right), .alu_out(s_alu_out),
    .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .wb_data(s_wb_data),
    .dbg_ra(s_dbg), .dbg_rdata(s_dbg_rdata)
  );

  function automatic ins_t mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                              input logic [3:0] rb, input logic use_imm, input logic [15:0] imm);
    mk.vld     = 1'b1;
    mk.op      = op;
    mk.rd      = rd;
    mk.ra      = ra;
    mk.rb      = rb;
    mk.use_imm = use_imm;
    mk.imm     = imm;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    f_in  = '0;
    s_in  = '0;
    f_dbg = '0;
    s_dbg = '0;
    #12;
    check("rst_f_rdy", 32'(f_rdy), 32'd1);
    check("rst_s_rdy", 32'(s_rdy), 32'd1);
    check("rst_f_wbv", 32'(f_wb_valid), 32'd0);
    rst = 1'b0;
    #1;

    // Reset state
    for (int i = 0; i < 16; i++) begin
      f_dbg = 4'(i);
      s_dbg = 4'(i);
      #1;
      check("rst_f_reg", f_dbg_rdata, 32'd0);
      check("rst_s_reg", s_dbg_rdata, 32'd0);
    end
    check("post_rst_f_rdy",  32'(f_rdy), 32'd1);
    check("post_rst_s_rdy",  32'(s_rdy), 32'd1);
    check("post_rst_f_wbv",  32'(f_wb_valid), 32'd0);
    check("post_rst_f_wbrd", 32'(f_wb_rd), 32'd0);
    check("post_rst_f_wbd",  f_wb_data, 32'd0);
    check("post_rst_f_op",   32'(f_alu_op), 32'd0);
    check("post_rst_f_l",    f_alu_left, 32'd0);
    check("post_rst_f_r",    f_alu_right, 32'd0);
    check("post_rst_s_l",    s_alu_left, 32'd0);
    check("post_rst_s_r",    s_alu_right, 32'd0);

    // Forwarding back-to-back
    tick;
    f_in = mk(4'h0, 4'd1, 4'd0, 4'd0, 1'b1, 16'h0005);
    #1 check("fwd_i1_rdy", 32'(f_rdy), 32'd1);
    tick;
    check("fwd_i1_op", 32'(f_alu_op), 32'h0);
    check("fwd_i1_l",  f_alu_left, 32'd0);
    check("fwd_i1_r",  f_alu_right, 32'd5);
    f_in = mk(4'h2, 4'd2, 4'd1, 4'd1, 1'b0, 16'h0000);
    #1 check("fwd_i2_rdy", 32'(f_rdy), 32'd1);
    tick;
    check("fwd_i2_op",   32'(f_alu_op), 32'h2);
    check("fwd_i2_l",    f_alu_left, 32'd5);
    check("fwd_i2_r",    f_alu_right, 32'd5);
    check("fwd_wb1_v",   32'(f_wb_valid), 32'd1);
    check("fwd_wb1_rd",  32'(f_wb_rd), 32'd1);
    check("fwd_wb1_d",   f_wb_data, 32'd5);
    f_in = '0;
    tick;
    check("fwd_wb2_v",   32'(f_wb_valid), 32'd1);
    check("fwd_wb2_rd",  32'(f_wb_rd), 32'd2);
    check("fwd_wb2_d",   f_wb_data, 32'd10);
    f_dbg = 4'd1;
    #1 check("fwd_r1", f_dbg_rdata, 32'd5);
    f_dbg = 4'd2;
    #1 check("fwd_r2", f_dbg_rdata, 32'd10);
    tick;
    check("fwd_idle_v",  32'(f_wb_valid), 32'd0);
    check("fwd_idle_d",  f_wb_data, 32'd10);

    // Stall path, same pair
    s_in = mk(4'h0, 4'd1, 4'd0, 4'd0, 1'b1, 16'h0005);
    #1 check("stl_i1_rdy", 32'(s_rdy), 32'd1);
    tick;
    s_in = mk(4'h2, 4'd2, 4'd1, 4'd1, 1'b0, 16'h0000);
    #1 check("stl_hz_rdy", 32'(s_rdy), 32'd0);
    tick;
    check("stl_bub_rdy", 32'(s_rdy), 32'd1);
    check("stl_bub_l",   s_alu_left, 32'd0);
    check("stl_bub_r",   s_alu_right, 32'd5);
    check("stl_wb1_v",   32'(s_wb_valid), 32'd1);
    check("stl_wb1_d",   s_wb_data, 32'd5);
    s_dbg = 4'd1;
    #1 check("stl_r1", s_dbg_rdata, 32'd5);
    tick;
    check("stl_i2_op",   32'(s_alu_op), 32'h2);
    check("stl_i2_l",    s_alu_left, 32'd5);
    check("stl_i2_r",    s_alu_right, 32'd5);
    check("stl_bub_wbv", 32'(s_wb_valid), 32'd0);
    s_in = '0;
    tick;
    check("stl_wb2_v",   32'(s_wb_valid), 32'd1);
    check("stl_wb2_rd",  32'(s_wb_rd), 32'd2);
    check("stl_wb2_d",   s_wb_data, 32'd10);
    s_dbg = 4'd2;
    #1 check("stl_r2", s_dbg_rdata, 32'd10);

    // r0 write then r0 read, both instances
    f_in = mk(4'he, 4'd0, 4'd0, 4'd0, 1'b1, 16'h1234);
    s_in = f_in;
    tick;
    f_in = mk(4'h2, 4'd6, 4'd0, 4'd0, 1'b0, 16'h0000);
    s_in = f_in;
    #1;
    check("r0_f_rdy", 32'(f_rdy), 32'd1);
    check("r0_s_rdy", 32'(s_rdy), 32'd1);
    tick;
    check("r0_f_l",    f_alu_left, 32'd0);
    check("r0_f_r",    f_alu_right, 32'd0);
    check("r0_s_l",    s_alu_left, 32'd0);
    check("r0_f_wbv",  32'(f_wb_valid), 32'd1);
    check("r0_f_wbrd", 32'(f_wb_rd), 32'd0);
    check("r0_f_wbd",  f_wb_data, 32'h0000_1234);
    check("r0_s_wbd",  s_wb_data, 32'h0000_1234);
    f_in  = '0;
    s_in  = '0;
    f_dbg = 4'd0;
    s_dbg = 4'd0;
    #1;
    check("r0_f_reg", f_dbg_rdata, 32'd0);
    check("r0_s_reg", s_dbg_rdata, 32'd0);
    tick;
    check("r0_f_wb6rd", 32'(f_wb_rd), 32'd6);
    check("r0_f_wb6d",  f_wb_data, 32'd0);

    // Stall ignores rb when the immediate is used; regfile read after writeback
    s_in = mk(4'he, 4'd7, 4'd0, 4'd0, 1'b1, 16'h0011);
    tick;
    s_in = mk(4'he, 4'd8, 4'd0, 4'd7, 1'b1, 16'h0022);
    #1 check("imm_s_rdy", 32'(s_rdy), 32'd1);
    tick;
    check("imm_s_r",   s_alu_right, 32'h22);
    check("imm_s_wbd", s_wb_data, 32'h11);
    s_in = mk(4'h2, 4'd9, 4'd7, 4'd7, 1'b0, 16'h0000);
    #1 check("rd7_s_rdy", 32'(s_rdy), 32'd1);
    tick;
    check("rd7_s_l", s_alu_left, 32'h11);
    check("rd7_s_r", s_alu_right, 32'h11);
    s_in = '0;

    // Sign extension and forwarded merge
    f_in = mk(4'he, 4'd3, 4'd0, 4'd0, 1'b1, 16'h8000);
    tick;
    check("sx_f_r", f_alu_right, 32'hFFFF_8000);
    f_in = mk(4'hf, 4'd4, 4'd3, 4'd0, 1'b1, 16'hABCD);
    #1 check("sx_f_rdy", 32'(f_rdy), 32'd1);
    tick;
    check("sx_f_l",   f_alu_left, 32'hFFFF_8000);
    check("sx_f_r2",  f_alu_right, 32'hFFFF_ABCD);
    check("sx_f_wbd", f_wb_data, 32'hFFFF_8000);
    f_in = '0;
    tick;
    check("sx_f_wbrd", 32'(f_wb_rd), 32'd4);
    check("sx_f_wbd2", f_wb_data, 32'hABCD_8000);
    f_dbg = 4'd3;
    #1 check("sx_r3", f_dbg_rdata, 32'hFFFF_8000);
    f_dbg = 4'd4;
    #1 check("sx_r4", f_dbg_rdata, 32'hABCD_8000);

    // Reset with an instruction in E
    tick;
    f_in = mk(4'he, 4'd5, 4'd0, 4'd0, 1'b1, 16'h0042);
    tick;
    f_in = '0;
    #1 rst = 1'b1;
    #1;
    check("mrst_wbv", 32'(f_wb_valid), 32'd0);
    check("mrst_r",   f_alu_right, 32'd0);
    check("mrst_op",  32'(f_alu_op), 32'd0);
    rst = 1'b0;
    #1 check("mrst_rdy", 32'(f_rdy), 32'd1);
    tick;
    check("mrst_wbv2", 32'(f_wb_valid), 32'd0);
    f_dbg = 4'd5;
    #1 check("mrst_r5", f_dbg_rdata, 32'd0);
    f_dbg = 4'd4;
    #1 check("mrst_r4", f_dbg_rdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
